multi_ball_renderer: RTL and testbench

//  Parametrised N-ball VGA sprite engine; sits between hvsync_generator and the uo_out RGB/sync pin mux.
//  Per frame, a sequential FSM advances each ball one per clock during vertical blanking; each ball bounces off the active-area edges.
//  Per pixel, a 1-stage pipeline renders the disc with the lowest-index hit and delays the syncs by the same amount.

---
 rtl/multi_ball_renderer.sv | 158 +++++++++++++++
 tb/tb_multi_ball_renderer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_ball_renderer.sv
// N-ball VGA sprite engine: per-frame bounce update FSM plus a 1-clk pixel/sync pipeline.
// Optional shadow ring around each ball is enabled by defining SHADOW_EN.
module multi_ball_renderer #(
    parameter int          NUM_BALLS   = 4,
    parameter int          RADIUS      = 20,
    parameter int          H_ACTIVE    = 640,
    parameter int          V_ACTIVE    = 480,
    parameter logic [23:0] BALL_COLORS = 24'hE_3C_F_0C,
    parameter logic [5:0]  BG_COLOR    = 6'b00_00_10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    input  logic       display_on,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [2:0] speed,
    input  logic       pause,
    output logic [5:0] rgb,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       busy
);

    localparam int          IDX_W  = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
    localparam logic [22:0] HIT_R2 = 23'(RADIUS * RADIUS);
`ifdef SHADOW_EN
    localparam logic [22:0] SHD_R2       = 23'((RADIUS + 4) * (RADIUS + 4));
    localparam logic [5:0]  SHADOW_COLOR = 6'b01_01_01;
`endif

    typedef enum logic {IDLE, UPD} state_t;

    state_t                       state, next_state;
    logic [IDX_W-1:0]             idx;
    logic [2:0]                   spd;
    logic                         frame_start;
    logic                         start_upd;
    logic                         last_ball;
    logic [NUM_BALLS-1:0][10:0]   ball_x, ball_y;
    logic [NUM_BALLS-1:0]         dir_x, dir_y;
    logic [NUM_BALLS-1:0]         hit;
`ifdef SHADOW_EN
    logic [NUM_BALLS-1:0]         shd;
`endif
    logic [5:0]                   pix;
    logic [5:0]                   rgb_p1;
    logic                         hsync_p1, vsync_p1;

    // Moves one axis by spd and clamps against the edge, reflecting direction.
    // Returns {dir, pos}; dir 1 = increasing coordinate.
    function automatic logic [11:0] axis_step(input logic [10:0] pos, input logic dir,
                                              input logic [2:0] step, input int active);
        logic [10:0] hi, lo, stp, n;
        hi  = 11'(active - 1 - RADIUS);
        lo  = 11'(RADIUS);
        stp = {8'd0, step};
        if (dir) begin
            n = pos + stp;
            if (n >= hi) return {1'b0, hi};
            else         return {1'b1, n};
        end else begin
            if (pos <= lo + stp) return {1'b1, lo};
            else                 return {1'b0, pos - stp};
        end
    endfunction

    assign frame_start = (hpos == 10'd0) && (vpos == 10'(V_ACTIVE));
    assign start_upd   = (state == IDLE) && frame_start && !pause;
    assign last_ball   = (idx == IDX_W'(NUM_BALLS - 1));
    assign busy        = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_upd) next_state = UPD;
            UPD:     if (last_ball) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx <= '0;
            spd <= '0;
            for (int i = 0; i < NUM_BALLS; i++) begin
                ball_x[i] <= 11'(H_ACTIVE / 2 + i * (2 * RADIUS + 4));
                ball_y[i] <= 11'(V_ACTIVE / 2);
                dir_x[i]  <= ((i & 1) == 0);
                dir_y[i]  <= ((i & 2) == 0);
            end
        end else if (start_upd) begin
            spd <= speed;
            idx <= '0;
        end else if (state == UPD) begin
            if (!last_ball) idx <= idx + 1'b1;
            for (int i = 0; i < NUM_BALLS; i++) begin
                if (idx == IDX_W'(i)) begin
                    {dir_x[i], ball_x[i]} <= axis_step(ball_x[i], dir_x[i], spd, H_ACTIVE);
                    {dir_y[i], ball_y[i]} <= axis_step(ball_y[i], dir_y[i], spd, V_ACTIVE);
                end
            end
        end
    end

    // Distance test per ball; squares stay exact because |d| < 1024.
    for (genvar g = 0; g < NUM_BALLS; g++) begin : g_ball
        logic signed [10:0] dx, dy;
        logic [21:0]        dxe, dye, sqx, sqy;
        logic [22:0]        sum;
        assign dx  = $signed({1'b0, hpos}) - $signed(ball_x[g]);
        assign dy  = $signed({1'b0, vpos}) - $signed(ball_y[g]);
        assign dxe = {{11{dx[10]}}, dx};
        assign dye = {{11{dy[10]}}, dy};
        assign sqx = dxe * dxe;
        assign sqy = dye * dye;
        assign sum = {1'b0, sqx} + {1'b0, sqy};
        assign hit[g] = (sum <= HIT_R2);
`ifdef SHADOW_EN
        assign shd[g] = (sum <= SHD_R2);
`endif
    end

    always_comb begin
        pix = BG_COLOR;
`ifdef SHADOW_EN
        if (|shd) pix = SHADOW_COLOR;
`endif
        for (int i = NUM_BALLS - 1; i >= 0; i--) begin
            if (hit[i]) pix = BALL_COLORS[6*i +: 6];
        end
        if (!display_on) pix = 6'd0;
    end

    // Stage p1: registered pixel colour with syncs delayed to match
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rgb_p1   <= '0;
            hsync_p1 <= 1'b0;
            vsync_p1 <= 1'b0;
        end else begin
            rgb_p1   <= pix;
            hsync_p1 <= hsync_in;
            vsync_p1 <= vsync_in;
        end
    end

    assign rgb       = rgb_p1;
    assign hsync_out = hsync_p1;
    assign vsync_out = vsync_p1;

endmodule

// File: tb/tb_multi_ball_renderer.sv
// Directed bench for multi_ball_renderer: reset, update, bounce, pause, pixel priority, shadow.
module tb_multi_ball_renderer;

    localparam int NB = 4;
    localparam logic [5:0] C0 = 6'b001100;
    localparam logic [5:0] C1 = 6'b111100;
    localparam logic [5:0] BG = 6'b000010;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] hpos = 10'd0;
    logic [9:0] vpos = 10'd481;
    logic       display_on = 1'b0;
    logic       hsync_in = 1'b0;
    logic       vsync_in = 1'b0;
    logic [2:0] speed = 3'd0;
    logic       pause = 1'b0;
    logic [5:0] rgb;
    logic       hsync_out, vsync_out, busy;

    int checks = 0;
    int failures = 0;

    multi_ball_renderer dut (
        .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos), .display_on(display_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .speed(speed), .pause(pause),
        .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic run_frame(input logic [2:0] s, input logic p, output int busy_cnt);
        speed = s;
        pause = p;
        hpos = 10'd0;
        vpos = 10'd480;
        tick();
        vpos = 10'd481;
        busy_cnt = busy ? 1 : 0;
        repeat (NB + 2) begin
            tick();
            if (busy) busy_cnt++;
        end
        pause = 1'b0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        display_on = 1'b0;
        vpos = 10'd481;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic pixel(input int x, input int y, input logic de);
        hpos = 10'(x);
        vpos = 10'(y);
        display_on = de;
        tick();
    endtask

    task automatic test_reset;
        do_reset();
        if (rgb !== 6'd0) begin failures++; $display("FAIL reset_rgb got=%0d exp=0", rgb); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0d exp=0", busy); end
        checks++;
        if (hsync_out !== 1'b0) begin failures++; $display("FAIL reset_hsync got=%0d exp=0", hsync_out); end
        checks++;
        if (dut.ball_x[0] !== 11'd320) begin failures++; $display("FAIL reset_x0 got=%0d exp=320", dut.ball_x[0]); end
        checks++;
        if (dut.ball_y[0] !== 11'd240) begin failures++; $display("FAIL reset_y0 got=%0d exp=240", dut.ball_y[0]); end
        checks++;
        if (dut.ball_x[1] !== 11'd364) begin failures++; $display("FAIL reset_x1 got=%0d exp=364", dut.ball_x[1]); end
        checks++;
        if (dut.ball_y[1] !== 11'd240) begin failures++; $display("FAIL reset_y1 got=%0d exp=240", dut.ball_y[1]); end
        checks++;
    endtask

    task automatic test_sync_delay;
        hsync_in = 1'b1;
        vsync_in = 1'b0;
        tick();
        if (hsync_out !== 1'b1 || vsync_out !== 1'b0) begin
            failures++;
            $display("FAIL sync_a got=%0d%0d exp=10", hsync_out, vsync_out);
        end
        checks++;
        hsync_in = 1'b0;
        vsync_in = 1'b1;
        tick();
        if (hsync_out !== 1'b0 || vsync_out !== 1'b1) begin
            failures++;
            $display("FAIL sync_b got=%0d%0d exp=01", hsync_out, vsync_out);
        end
        checks++;
        vsync_in = 1'b0;
    endtask

    task automatic test_pixel;
        pixel(320, 240, 1'b1);
        if (rgb !== C0) begin failures++; $display("FAIL pix_ball0 got=%0d exp=%0d", rgb, C0); end
        checks++;
        pixel(384, 240, 1'b1);
        if (rgb !== C1) begin failures++; $display("FAIL pix_ball1 got=%0d exp=%0d", rgb, C1); end
        checks++;
        pixel(100, 100, 1'b1);
        if (rgb !== BG) begin failures++; $display("FAIL pix_bg got=%0d exp=%0d", rgb, BG); end
        checks++;
        pixel(320, 240, 1'b0);
        if (rgb !== 6'd0) begin failures++; $display("FAIL pix_blank got=%0d exp=0", rgb); end
        checks++;
    endtask

    task automatic test_update;
        int n;
        run_frame(3'd2, 1'b0, n);
        if (n != NB) begin failures++; $display("FAIL upd_busy got=%0d exp=%0d", n, NB); end
        checks++;
        if (dut.ball_x[0] !== 11'd322 || dut.ball_y[0] !== 11'd242) begin
            failures++;
            $display("FAIL upd_b0 got=(%0d,%0d) exp=(322,242)", dut.ball_x[0], dut.ball_y[0]);
        end
        checks++;
        if (dut.ball_x[1] !== 11'd362 || dut.ball_y[1] !== 11'd242) begin
            failures++;
            $display("FAIL upd_b1 got=(%0d,%0d) exp=(362,242)", dut.ball_x[1], dut.ball_y[1]);
        end
        checks++;
        if (dut.ball_x[3] !== 11'd450 || dut.ball_y[3] !== 11'd238) begin
            failures++;
            $display("FAIL upd_b3 got=(%0d,%0d) exp=(450,238)", dut.ball_x[3], dut.ball_y[3]);
        end
        checks++;
    endtask

    task automatic test_overlap;
        pixel(342, 242, 1'b1);
        if (rgb !== C0) begin failures++; $display("FAIL overlap got=%0d exp=%0d", rgb, C0); end
        checks++;
        pixel(362, 242, 1'b1);
        if (rgb !== C1) begin failures++; $display("FAIL moved_b1 got=%0d exp=%0d", rgb, C1); end
        checks++;
        display_on = 1'b0;
    endtask

    task automatic test_pause;
        int n;
        run_frame(3'd5, 1'b1, n);
        if (n != 0) begin failures++; $display("FAIL pause_busy got=%0d exp=0", n); end
        checks++;
        if (dut.ball_x[0] !== 11'd322 || dut.ball_y[0] !== 11'd242) begin
            failures++;
            $display("FAIL pause_pos got=(%0d,%0d) exp=(322,242)", dut.ball_x[0], dut.ball_y[0]);
        end
        checks++;
        run_frame(3'd0, 1'b0, n);
        if (n != NB) begin failures++; $display("FAIL freeze_busy got=%0d exp=%0d", n, NB); end
        checks++;
        if (dut.ball_x[1] !== 11'd362 || dut.ball_y[1] !== 11'd242) begin
            failures++;
            $display("FAIL freeze_pos got=(%0d,%0d) exp=(362,242)", dut.ball_x[1], dut.ball_y[1]);
        end
        checks++;
    endtask

    task automatic test_bounce;
        int n;
        do_reset();
        repeat (42) run_frame(3'd7, 1'b0, n);
        if (dut.ball_x[0] !== 11'd614 || dut.dir_x[0] !== 1'b1) begin
            failures++;
            $display("FAIL bounce_pre got=%0d/%0d exp=614/1", dut.ball_x[0], dut.dir_x[0]);
        end
        checks++;
        run_frame(3'd3, 1'b0, n);
        if (dut.ball_x[0] !== 11'd617) begin failures++; $display("FAIL bounce_617 got=%0d exp=617", dut.ball_x[0]); end
        checks++;
        run_frame(3'd3, 1'b0, n);
        if (dut.ball_x[0] !== 11'd619 || dut.dir_x[0] !== 1'b0) begin
            failures++;
            $display("FAIL bounce_edge got=%0d/%0d exp=619/0", dut.ball_x[0], dut.dir_x[0]);
        end
        checks++;
        run_frame(3'd3, 1'b0, n);
        if (dut.ball_x[0] !== 11'd616) begin failures++; $display("FAIL bounce_back got=%0d exp=616", dut.ball_x[0]); end
        checks++;
    endtask

    task automatic test_shadow;
        logic [5:0] exp_ring;
`ifdef SHADOW_EN
        exp_ring = 6'b010101;
`else
        exp_ring = BG;
`endif
        do_reset();
        pixel(342, 240, 1'b1);
        if (rgb !== exp_ring) begin failures++; $display("FAIL shadow_ring got=%0d exp=%0d", rgb, exp_ring); end
        checks++;
        pixel(340, 240, 1'b1);
        if (rgb !== C0) begin failures++; $display("FAIL shadow_prio got=%0d exp=%0d", rgb, C0); end
        checks++;
        display_on = 1'b0;
        vpos = 10'd481;
    endtask

    task automatic test_reset_mid_upd;
        speed = 3'd2;
        hpos = 10'd0;
        vpos = 10'd480;
        tick();
        vpos = 10'd481;
        tick();
        tick();
        if (dut.ball_x[0] !== 11'd322 || busy !== 1'b1) begin
            failures++;
            $display("FAIL midupd_pre got=%0d/%0d exp=322/1", dut.ball_x[0], busy);
        end
        checks++;
        rst_n = 1'b0;
        tick();
        if (busy !== 1'b0 || dut.ball_x[0] !== 11'd320 || dut.ball_x[1] !== 11'd364) begin
            failures++;
            $display("FAIL midupd_rst got=%0d/%0d/%0d exp=0/320/364", busy, dut.ball_x[0], dut.ball_x[1]);
        end
        checks++;
        rst_n = 1'b1;
        tick();
        if (busy !== 1'b0) begin failures++; $display("FAIL midupd_idle got=%0d exp=0", busy); end
        checks++;
    endtask

    initial begin
        test_reset();
        test_sync_delay();
        test_pixel();
        test_update();
        test_overlap();
        test_pause();
        test_bounce();
        test_shadow();
        test_reset_mid_upd();
        chk("total_checks_nonzero", (checks > 30) ? 1 : 0, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
